// File: rtl/key_scanner.sv
// 8x8 keyboard matrix scanner: strobes one row at a time, debounces every key over two
// consecutive frame samples, and reports press/release events through a valid/ack handshake.
module key_scanner #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] row_select,
    input  logic [7:0] key_in,
    output logic [7:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic [1:0] dbg_state
);

    // Handshake: an event is offered while key_valid is high; key_code is stable for
    // that whole time, and the event is consumed on a rising edge with key_valid & key_ack.
    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        EVAL   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      r;
    logic [15:0]     dwell;
    logic [7:0]      samp;
    logic [7:0][7:0] raw;
    logic [7:0][7:0] deb;
    logic [7:0]      chg;
    logic [2:0]      c_sel;

    assign row_select = ~(8'd1 << r);
    assign dbg_state  = state;

    // A key qualifies only when this sample matches the previous frame's sample
    // and disagrees with its debounced state.
    always_comb begin
        chg   = ~(samp ^ raw[r]) & (samp ^ deb[r]);
        c_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (chg[i]) c_sel = i[2:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SCAN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:    if (dwell == DWELL_LAST) state_nxt = EVAL;
            EVAL:    state_nxt = (chg == 8'd0) ? SCAN : REPORT;
            REPORT:  if (key_ack) state_nxt = EVAL;
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r         <= 3'd0;
            dwell     <= 16'd0;
            samp      <= 8'hFF;
            raw       <= '1;
            deb       <= '1;
            key_code  <= 8'h00;
            key_valid <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        samp  <= key_in;
                        dwell <= 16'd0;
                    end else begin
                        dwell <= dwell + 16'd1;
                    end
                end
                EVAL: begin
                    // The row sample is committed to raw only once every change in it is reported.
                    if (chg == 8'd0) begin
                        raw[r] <= samp;
                        r      <= r + 3'd1;
                    end else begin
                        deb[r][c_sel] <= samp[c_sel];
                        key_code      <= {samp[c_sel], c_sel, 1'b0, r};
                        key_valid     <= 1'b1;
                    end
                end
                REPORT: begin
                    if (key_ack) key_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_scanner.sv
// Directed bench for key_scanner: a matrix model drives key_in from row_select, and a
// monitor pops expected key codes from a queue whenever a new event is presented.
module tb_key_scanner;

    localparam int SCAN_DIV = 16;
    localparam int FRAME    = 8 * (SCAN_DIV + 1);

    logic       clk;
    logic       reset_n;
    logic [7:0] row_select;
    logic [7:0] key_in;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic [1:0] dbg_state;

    logic [7:0][7:0] pressed;   // pressed[row][col] = 1 when the physical key is down

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         auto_ack = 0;
    logic [7:0] exp_q[$];
    int         ev_cyc[$];

    key_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .row_select (row_select),
        .key_in     (key_in),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ack    (key_ack),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- matrix model ----------------
    always_comb begin
        key_in = 8'hFF;
        for (int rr = 0; rr < 8; rr++) begin
            if (!row_select[rr]) key_in = key_in & ~pressed[rr];
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_row(input logic [7:0] v);
        int t = 0;
        while (row_select !== v && t < 2 * FRAME) begin
            @(negedge clk);
            t++;
        end
        check("wait_row", {24'd0, row_select}, {24'd0, v});
    endtask

    task automatic wait_leave_row(input logic [7:0] v);
        int t = 0;
        while (row_select === v && t < 4 * SCAN_DIV) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (row_select === v) begin
            n_errors++;
            $display("FAIL wait_leave_row: got %02h expected a different row", row_select);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit         checked;
        logic [7:0] e;
        logic [7:0] exp_rs;
        checked = 0;
        key_ack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!key_valid) begin
                checked = 0;
            end else if (!checked) begin
                checked = 1;
                ev_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got %02h expected none", key_code);
                end else begin
                    e      = exp_q.pop_front();
                    exp_rs = ~(8'd1 << e[2:0]);
                    check("key_code", {24'd0, key_code}, {24'd0, e});
                    check("row_at_event", {24'd0, row_select}, {24'd0, exp_rs});
                end
            end
            key_ack = auto_ack & key_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int         n0;
        int         t;
        int         bad;
        logic [7:0] rs0;
        logic [7:0] kc0;

        reset_n = 1'b0;
        pressed = '0;
        wait_cycles(3);
        check("rst_row_select", {24'd0, row_select}, 32'hFE);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_code", {24'd0, key_code}, 32'h00);
        check("rst_state", {30'd0, dbg_state}, 32'd0);

        // Reset asserted mid-scan, then measure first row advance.
        reset_n = 1'b1;
        wait_cycles(40);
        reset_n = 1'b0;
        #1;
        check("midrst_row_select", {24'd0, row_select}, 32'hFE);
        check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
        check("midrst_key_code", {24'd0, key_code}, 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        t = 0;
        while (row_select !== 8'hFD && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("first_row_advance_cycles", t, SCAN_DIV + 1);

        auto_ack = 1;

        // Single press and release of (row 2, col 5).
        exp_q.push_back(8'h52);
        pressed[2][5] = 1'b1;
        wait_cycles(3 * FRAME);
        check("press_queue_drained", exp_q.size(), 0);
        exp_q.push_back(8'hD2);
        pressed[2][5] = 1'b0;
        wait_cycles(3 * FRAME);
        check("release_queue_drained", exp_q.size(), 0);

        // One-visit bounce on (row 7, col 0).
        n0 = ev_cyc.size();
        wait_row(8'h7F);
        pressed[7][0] = 1'b1;
        wait_leave_row(8'h7F);
        pressed[7][0] = 1'b0;
        wait_cycles(3 * FRAME);
        check("bounce_no_event", ev_cyc.size(), n0);

        // Two keys in row 3, reported in consecutive EVALs.
        n0 = ev_cyc.size();
        exp_q.push_back(8'h13);
        exp_q.push_back(8'h63);
        pressed[3][1] = 1'b1;
        pressed[3][6] = 1'b1;
        wait_cycles(3 * FRAME);
        check("multi_event_count", ev_cyc.size(), n0 + 2);
        if (ev_cyc.size() >= n0 + 2)
            check("multi_event_spacing", ev_cyc[n0+1] - ev_cyc[n0], 2);
        exp_q.push_back(8'h93);
        exp_q.push_back(8'hE3);
        pressed[3][1] = 1'b0;
        pressed[3][6] = 1'b0;
        wait_cycles(3 * FRAME);
        check("multi_release_drained", exp_q.size(), 0);

        // Back-pressure: hold the (row 0, col 4) event for 1000 cycles.
        auto_ack = 0;
        wait_row(8'h7F);
        wait_row(8'hFE);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h25);
        pressed[0][4] = 1'b1;
        pressed[5][2] = 1'b1;
        t = 0;
        while (!key_valid && t < 3 * FRAME) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_seen", {31'd0, key_valid}, 32'd1);
        rs0 = row_select;
        kc0 = key_code;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (row_select !== rs0 || key_code !== kc0 || key_valid !== 1'b1) bad++;
        end
        check("bp_stable_violations", bad, 0);
        check("bp_key_code", {24'd0, key_code}, 32'h40);
        check("bp_row_select", {24'd0, row_select}, 32'hFE);
        check("bp_state", {30'd0, dbg_state}, 32'd2);
        auto_ack = 1;
        wait_cycles(3 * FRAME);
        check("bp_queue_drained", exp_q.size(), 0);

        // Reset while an event is pending; held keys are re-reported afterwards.
        auto_ack = 0;
        exp_q.push_back(8'h76);
        pressed[6][7] = 1'b1;
        t = 0;
        while (!key_valid && t < 3 * FRAME) begin
            @(negedge clk);
            t++;
        end
        check("rr_valid_seen", {31'd0, key_valid}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rr_valid_dropped", {31'd0, key_valid}, 32'd0);
        check("rr_row_select", {24'd0, row_select}, 32'hFE);
        @(negedge clk);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h25);
        exp_q.push_back(8'h76);
        auto_ack = 1;
        reset_n  = 1'b1;
        wait_cycles(3 * FRAME);
        check("rr_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
